// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT defines: complex type, frame-length helpers, bit reversal.
// Imported by the reorder buffer and any other FFT stage.
package fft_bitrev_reorder_pkg;

    localparam int STG_MAX = 12;
    localparam int CPLX_DW = 16;

    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

    function automatic int fft_len(input int stg);
        return 1 << stg;
    endfunction

    // Reverse the low stg bits of v; upper bits of the result are zero.
    function automatic logic [STG_MAX-1:0] bitrev(
        input logic [STG_MAX-1:0] v,
        input int stg
    );
        logic [STG_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < STG_MAX; i++) begin
            if (i < stg) r[stg-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Two-bank simple dual-port RAM with registered read.
// The bank bit is the address MSB; contents are not reset.
module fft_reorder_ram #(
    parameter int AW = 5,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // write port
    always_ff @(posedge clk) begin
        if (en && we) mem[waddr] <= wdata;
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (en) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer for streaming FFT frames.
// One bank fills while the other drains in the complementary order.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int STG    = 4,
    parameter int DW     = 16,
    parameter int REV_IN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic          in_sync,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_valid,
    output logic          out_sync,
    output logic          err
);

    localparam int LEN = fft_len(STG);
    localparam logic [STG-1:0] LAST = STG'(LEN - 1);

    logic [STG-1:0] wcnt;
    logic [STG-1:0] rcnt;
    logic           wbank;
    logic           rbank;
    logic           rd_act;
    logic           rv;
    logic           rs;
    logic           frame_done;
    logic           bad_sync;
    logic [STG:0]   waddr;
    logic [STG:0]   raddr;
    logic [2*DW-1:0] rdata;

    assign frame_done = en && (wcnt == LAST);
    assign bad_sync   = en && in_sync && (wcnt != LAST);

    assign waddr = {wbank, (REV_IN != 0) ? STG'(bitrev(STG_MAX'(wcnt), STG)) : wcnt};
    assign raddr = {rbank, (REV_IN != 0) ? rcnt : STG'(bitrev(STG_MAX'(rcnt), STG))};

    fft_reorder_ram #(
        .AW (STG + 1),
        .W  (2 * DW)
    ) u_ram (
        .clk   (clk),
        .en    (en),
        .we    (en),
        .waddr (waddr),
        .wdata ({in_re, in_im}),
        .raddr (raddr),
        .rdata (rdata)
    );

    // write counter, bank toggle on frame completion, resync on early in_sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            err   <= 1'b0;
        end else if (en) begin
            err <= bad_sync;
            if (frame_done) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else if (in_sync) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    // read sequencer: a completed bank restarts the readout immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt   <= '0;
            rbank  <= 1'b0;
            rd_act <= 1'b0;
        end else if (en) begin
            if (frame_done) begin
                rd_act <= 1'b1;
                rcnt   <= '0;
                rbank  <= wbank;
            end else if (rd_act) begin
                if (rcnt == LAST) rd_act <= 1'b0;
                else              rcnt   <= rcnt + 1'b1;
            end
        end
    end

    // valid/sync tracking alongside the RAM read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv <= 1'b0;
            rs <= 1'b0;
        end else if (en) begin
            rv <= rd_act;
            rs <= rd_act && (rcnt == LAST);
        end
    end

    // output register; data holds while no sample is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
            out_sync  <= 1'b0;
        end else if (en) begin
            out_valid <= rv;
            out_sync  <= rs;
            if (rv) begin
                out_re <= rdata[2*DW-1:DW];
                out_im <= rdata[DW-1:0];
            end
        end
    end

endmodule
